// File: rtl/size_accum.sv
// Multi-channel saturating/flooring size accumulator with a two-stage
// read-modify-write pipeline, same-channel bypass and per-channel clear.
module size_accum #(
  parameter int NCH   = 4,
  parameter int SW    = 32,
  parameter int AW    = 16,
  parameter int HDR_A = 32,
  parameter int HDR_B = 48
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   op_vld,
  input  logic [$clog2((NCH > 1) ? NCH : 2)-1:0] op_ch,
  input  logic [2:0]                             op_code,
  input  logic [AW-1:0]                          op_arg,
  input  logic                                   op_hsel,
  input  logic [NCH-1:0]                         clr,
  output logic [NCH*SW-1:0]                      size,
  output logic [NCH-1:0]                         ovf,
  output logic [NCH-1:0]                         udf,
  output logic [NCH-1:0]                         zero,
  output logic                                   upd_vld,
  output logic [$clog2((NCH > 1) ? NCH : 2)-1:0] upd_ch
);

  localparam int CW = $clog2((NCH > 1) ? NCH : 2);

  localparam logic [2:0] OP_LOAD   = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_ADDHDR = 3'b011;
  localparam logic [2:0] OP_CLR    = 3'b100;

  localparam logic [SW-1:0] HDR_A_W = SW'(HDR_A);
  localparam logic [SW-1:0] HDR_B_W = SW'(HDR_B);

  // Result in [SW-1:0], saturation flag in [SW].
  function automatic logic [SW:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SW] ? {1'b1, {SW{1'b1}}} : s;
  endfunction

  // Result in [SW-1:0], floor flag in [SW].
  function automatic logic [SW:0] floor_sub(input logic [SW-1:0] a, input logic [SW-1:0] b);
    return (b > a) ? {1'b1, {SW{1'b0}}} : {1'b0, a - b};
  endfunction

  logic [SW-1:0] size_r [NCH];

  logic          vld_p1;
  logic [SW-1:0] res_p1;
  logic [CW-1:0] ch_p1;
  logic          ovf_p1;
  logic          udf_p1;
  logic          clrop_p1;

  logic          hit_ch;
  logic          clr_hit;
  logic [SW-1:0] cur_size;
  logic [SW-1:0] base;
  logic [SW-1:0] addend;
  logic [SW:0]   add_r;
  logic [SW:0]   sub_r;
  logic [SW-1:0] res_n;
  logic          ovf_n;
  logic          udf_n;
  logic          clrop_n;
  logic          vld_n;
  logic [NCH-1:0] wr_en;

  // ---- stage 1: base select (clear > bypass > stored) and compute ----
  always_comb begin
    hit_ch   = 1'b0;
    clr_hit  = 1'b0;
    cur_size = '0;
    for (int i = 0; i < NCH; i++) begin
      if (op_ch == CW'(i)) begin
        hit_ch   = 1'b1;
        clr_hit  = clr[i];
        cur_size = size_r[i];
      end
    end

    if (clr_hit)
      base = '0;
    else if (vld_p1 && (ch_p1 == op_ch))
      base = res_p1;
    else
      base = cur_size;

    addend = (op_code == OP_ADDHDR) ? (op_hsel ? HDR_B_W : HDR_A_W) : SW'(op_arg);
    add_r  = sat_add(base, addend);
    sub_r  = floor_sub(base, SW'(op_arg));

    res_n   = '0;
    ovf_n   = 1'b0;
    udf_n   = 1'b0;
    clrop_n = 1'b0;
    vld_n   = op_vld && hit_ch;
    case (op_code)
      OP_LOAD:           res_n = SW'(op_arg);
      OP_ADD, OP_ADDHDR: {ovf_n, res_n} = add_r;
      OP_SUB:            {udf_n, res_n} = sub_r;
      OP_CLR:            clrop_n = 1'b1;
      default:           vld_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= vld_n;
  end

  always_ff @(posedge clk) begin
    res_p1   <= res_n;
    ch_p1    <= op_ch;
    ovf_p1   <= ovf_n;
    udf_p1   <= udf_n;
    clrop_p1 <= clrop_n;
  end

  // ---- stage 2: write-back; a clear on the same edge wins over the write ----
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NCH; i++)
      wr_en[i] = vld_p1 && (ch_p1 == CW'(i)) && !clr[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++)
        size_r[i] <= '0;
      ovf     <= '0;
      udf     <= '0;
      upd_vld <= 1'b0;
      upd_ch  <= '0;
    end else begin
      upd_vld <= |wr_en;
      if (|wr_en)
        upd_ch <= ch_p1;
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          size_r[i] <= '0;
          ovf[i]    <= 1'b0;
          udf[i]    <= 1'b0;
        end else if (wr_en[i]) begin
          size_r[i] <= res_p1;
          ovf[i]    <= !clrop_p1 && (ovf[i] || ovf_p1);
          udf[i]    <= !clrop_p1 && (udf[i] || udf_p1);
        end
      end
    end
  end

  always_comb begin
    size = '0;
    zero = '0;
    for (int i = 0; i < NCH; i++) begin
      size[i*SW +: SW] = size_r[i];
      zero[i]          = (size_r[i] == '0);
    end
  end

endmodule

// File: tb/tb_size_accum.sv
// Bench for size_accum: directed vector table, hand sequences for clear and
// async-reset corners, and random traffic against a logical-value model.
module tb_size_accum;
  localparam int NCH = 5;
  localparam int SW  = 16;
  localparam int AW  = 16;
  localparam int CW  = 3;

  localparam logic [2:0] LD = 3'd0, AD = 3'd1, SB = 3'd2, HD = 3'd3, CL = 3'd4;

  logic              clk = 1'b0;
  logic              rst;
  logic              op_vld;
  logic [CW-1:0]     op_ch;
  logic [2:0]        op_code;
  logic [AW-1:0]     op_arg;
  logic              op_hsel;
  logic [NCH-1:0]    clr;
  logic [NCH*SW-1:0] size;
  logic [NCH-1:0]    ovf;
  logic [NCH-1:0]    udf;
  logic [NCH-1:0]    zero;
  logic              upd_vld;
  logic [CW-1:0]     upd_ch;

  always #5 clk = ~clk;

  size_accum #(.NCH(NCH), .SW(SW), .AW(AW), .HDR_A(32), .HDR_B(48)) dut (
    .clk(clk), .rst(rst), .op_vld(op_vld), .op_ch(op_ch), .op_code(op_code),
    .op_arg(op_arg), .op_hsel(op_hsel), .clr(clr), .size(size), .ovf(ovf),
    .udf(udf), .zero(zero), .upd_vld(upd_vld), .upd_ch(upd_ch)
  );

  int n_tot  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Model: m_lv is the logical value after every accepted op; committed state
  // trails it by one pending write that a same-edge clear can cancel.
  longint         m_lv [NCH];
  logic [SW-1:0]  m_sz [NCH];
  logic [NCH-1:0] m_ovf, m_udf;
  logic           m_upd;
  logic [CW-1:0]  m_updch;
  logic           p_v, p_o, p_u, p_c;
  int             p_ch;
  logic [SW-1:0]  p_val;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_lv[i] = 0;
      m_sz[i] = '0;
    end
    m_ovf = '0; m_udf = '0; m_upd = 1'b0; m_updch = '0;
    p_v = 1'b0; p_o = 1'b0; p_u = 1'b0; p_c = 1'b0; p_ch = 0; p_val = '0;
  endtask

  task automatic model_edge();
    longint b, r, lim;
    int     c;
    lim   = (longint'(1) << SW) - 1;
    m_upd = 1'b0;
    if (p_v && !clr[p_ch]) begin
      m_sz[p_ch] = p_val;
      m_ovf[p_ch] = p_c ? 1'b0 : (m_ovf[p_ch] | p_o);
      m_udf[p_ch] = p_c ? 1'b0 : (m_udf[p_ch] | p_u);
      m_upd   = 1'b1;
      m_updch = CW'(p_ch);
    end
    for (int i = 0; i < NCH; i++) begin
      if (clr[i]) begin
        m_sz[i] = '0; m_ovf[i] = 1'b0; m_udf[i] = 1'b0; m_lv[i] = 0;
      end
    end
    p_v = 1'b0;
    c   = int'(op_ch);
    if (op_vld && c < NCH && op_code <= CL) begin
      b = m_lv[c]; p_o = 1'b0; p_u = 1'b0; p_c = 1'b0;
      case (op_code)
        LD: r = longint'(op_arg);
        AD: r = b + longint'(op_arg);
        SB: begin
          if (longint'(op_arg) > b) begin r = 0; p_u = 1'b1; end
          else r = b - longint'(op_arg);
        end
        HD: r = b + (op_hsel ? 48 : 32);
        default: begin r = 0; p_c = 1'b1; end
      endcase
      if (r > lim) begin r = lim; p_o = 1'b1; end
      m_lv[c] = r;
      p_v = 1'b1; p_ch = c; p_val = r[SW-1:0];
    end
  endtask

  task automatic compare_model();
    logic [NCH*SW-1:0] es;
    logic [NCH-1:0]    ez;
    for (int i = 0; i < NCH; i++) begin
      es[i*SW +: SW] = m_sz[i];
      ez[i] = (m_sz[i] == '0);
    end
    chk("m_size", size, es);
    chk("m_ovf", ovf, m_ovf);
    chk("m_udf", udf, m_udf);
    chk("m_zero", zero, ez);
    chk("m_upd_vld", upd_vld, m_upd);
    chk("m_upd_ch", upd_ch, m_updch);
  endtask

  task automatic cyc(input logic v, input logic [2:0] ch, input logic [2:0] code,
                     input logic [15:0] arg, input logic hs, input logic [4:0] cl);
    op_vld = v; op_ch = ch; op_code = code; op_arg = arg; op_hsel = hs; clr = cl;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic v; logic [2:0] ch; logic [2:0] code; logic [15:0] arg; logic hs; logic [4:0] cl;
    int ec; logic [15:0] esz; logic [4:0] eovf; logic [4:0] eudf; logic eupd; logic [2:0] euch;
  } vec_t;

  vec_t tbl [25];

  initial begin
    tbl[0]  = '{1, 1, LD, 100,     0, 0, 1, 0,       0, 0, 0, 0};
    tbl[1]  = '{1, 1, AD, 20,      0, 0, 1, 100,     0, 0, 1, 1};
    tbl[2]  = '{1, 1, HD, 0,       1, 0, 1, 120,     0, 0, 1, 1};
    tbl[3]  = '{0, 0, LD, 0,       0, 0, 1, 168,     0, 0, 1, 1};
    tbl[4]  = '{0, 0, LD, 0,       0, 0, 1, 168,     0, 0, 0, 0};
    tbl[5]  = '{1, 0, LD, 16'hFFF0, 0, 0, 0, 0,       0, 0, 0, 0};
    tbl[6]  = '{1, 0, AD, 16'h0020, 0, 0, 0, 16'hFFF0, 0, 0, 1, 0};
    tbl[7]  = '{1, 0, SB, 16'h0010, 0, 0, 0, 16'hFFFF, 1, 0, 1, 0};
    tbl[8]  = '{1, 0, CL, 0,       0, 0, 0, 16'hFFEF, 1, 0, 1, 0};
    tbl[9]  = '{0, 0, LD, 0,       0, 0, 0, 0,       0, 0, 1, 0};
    tbl[10] = '{1, 2, LD, 10,      0, 0, 2, 0,       0, 0, 0, 0};
    tbl[11] = '{1, 2, SB, 11,      0, 0, 2, 10,      0, 0, 1, 2};
    tbl[12] = '{0, 0, LD, 0,       0, 0, 2, 0,       0, 4, 1, 2};
    tbl[13] = '{1, 3, AD, 7,       0, 0, 3, 0,       0, 4, 0, 0};
    tbl[14] = '{1, 3, AD, 4,       0, 8, 3, 0,       0, 4, 0, 0};
    tbl[15] = '{0, 0, LD, 0,       0, 0, 3, 4,       0, 4, 1, 3};
    tbl[16] = '{0, 0, LD, 0,       0, 3, 1, 0,       0, 4, 0, 0};
    tbl[17] = '{1, 0, AD, 1,       0, 0, 0, 0,       0, 4, 0, 0};
    tbl[18] = '{1, 1, AD, 1,       0, 0, 0, 1,       0, 4, 1, 0};
    tbl[19] = '{1, 0, AD, 1,       0, 0, 1, 1,       0, 4, 1, 1};
    tbl[20] = '{1, 1, AD, 1,       0, 0, 0, 2,       0, 4, 1, 0};
    tbl[21] = '{0, 0, LD, 0,       0, 0, 1, 2,       0, 4, 1, 1};
    tbl[22] = '{1, 5, AD, 9,       0, 0, 1, 2,       0, 4, 0, 0};
    tbl[23] = '{1, 7, CL, 0,       0, 0, 2, 0,       0, 4, 0, 0};
    tbl[24] = '{0, 0, LD, 0,       0, 0, 4, 0,       0, 4, 0, 0};

    rst = 1'b1; op_vld = 1'b0; op_ch = '0; op_code = '0; op_arg = '0; op_hsel = 1'b0; clr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_size", size, '0);
    chk("rst_zero", zero, 5'h1F);
    chk("rst_upd_vld", upd_vld, 1'b0);
    chk("rst_flags", {ovf, udf}, '0);
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 25; k++) begin
      cyc(tbl[k].v, tbl[k].ch, tbl[k].code, tbl[k].arg, tbl[k].hs, tbl[k].cl);
      chk($sformatf("t%0d_size", k), size[tbl[k].ec*SW +: SW], tbl[k].esz);
      chk($sformatf("t%0d_zero", k), zero[tbl[k].ec], tbl[k].esz == 16'd0);
      chk($sformatf("t%0d_ovf", k), ovf, tbl[k].eovf);
      chk($sformatf("t%0d_udf", k), udf, tbl[k].eudf);
      chk($sformatf("t%0d_upd_vld", k), upd_vld, tbl[k].eupd);
      if (tbl[k].eupd)
        chk($sformatf("t%0d_upd_ch", k), upd_ch, tbl[k].euch);
    end

    // Async reset with two ops in flight, then a fresh op after release.
    cyc(1, 4, LD, 5, 0, 0);
    cyc(1, 4, AD, 6, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_size", size, '0);
    chk("mid_rst_zero", zero, 5'h1F);
    chk("mid_rst_flags", {ovf, udf}, '0);
    chk("mid_rst_upd", {upd_vld, upd_ch}, '0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    cyc(1, 4, LD, 9, 0, 0);
    chk("post_rst_e1_size4", size[4*SW +: SW], 16'd0);
    chk("post_rst_e1_upd", upd_vld, 1'b0);
    cyc(0, 0, LD, 0, 0, 0);
    chk("post_rst_e2_size4", size[4*SW +: SW], 16'd9);
    chk("post_rst_e2_upd", {upd_vld, upd_ch}, {1'b1, 3'd4});

    for (int k = 0; k < 400; k++) begin
      logic [2:0]  rc;
      logic [15:0] ra;
      logic [4:0]  rcl;
      rc  = ($urandom_range(0, 9) > 7) ? AD : 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
      rcl = '0;
      for (int i = 0; i < NCH; i++)
        rcl[i] = ($urandom_range(0, 15) == 0);
      cyc(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 5)), rc, ra,
          1'($urandom_range(0, 1)), rcl);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/size_accum.md
# size_accum

Parametrised multi-channel size accumulator: the next generation of the single-pair size0/size1 tracker. It is used wherever the command path keeps per-stream byte counts (payload, extended command length, hash-header length) and must also consume them. Ops pass through a two-stage pipeline with same-channel bypass. Adds are saturating and subtracts are floored, each raising a sticky flag. Each channel has a per-channel clear and a registered update strobe.

## Interface
- NCH, 4, number of independent channels (1..16)
- SW, 32, accumulator width per channel
- AW, 16, operand width (AW <= SW)
- HDR_A, 32, header increment when op_hsel=0
- HDR_B, 48, header increment when op_hsel=1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- op_vld  in  1  op request; accepted every cycle it is high (no backpressure)
- op_ch  in  clog2(NCH) (min 1)  target channel; values >= NCH are treated as NOP
- op_code  in  3  000 LOAD, 001 ADD, 010 SUB, 011 ADDHDR, 100 CLR, others NOP
- op_arg  in  AW  operand, zero-extended to SW
- op_hsel  in  1  header select for ADDHDR
- clr  in  NCH  per-channel synchronous clear mask
- size  out  NCH*SW  channel i at [i*SW +: SW], registered
- ovf  out  NCH  sticky: an ADD/ADDHDR saturated
- udf  out  NCH  sticky: a SUB floored at zero
- zero  out  NCH  size of channel i == 0, combinational from size
- upd_vld  out  1  pulse: a stage-2 write took effect this edge
- upd_ch  out  clog2(NCH)  channel written, valid with upd_vld

## Operation
- Stage 1 (edge E0, op_vld=1, valid channel): read base, compute result, register {res_q, ch_q, flag_q, v_q}.
- Base is res_q if v_q=1 and ch_q==op_ch (bypass). Otherwise base is the size of op_ch.
- LOAD: res = op_arg.
- ADD: res = base + op_arg.
- ADDHDR: res = base + (op_hsel ? HDR_B : HDR_A).
- ADD and ADDHDR are computed at SW+1 bits. On carry, res = all-ones and ovf is set at write.
- SUB: if op_arg > base then res = 0 and udf is set at write; else res = base - op_arg.
- CLR op: res = 0; clears ovf and udf of that channel at write.
- NOP and out-of-range op_ch: v_q=0; no write and no upd_vld.
- Stage 2 (edge E1): if v_q, write size[ch_q]=res_q. OR in the flags (CLR op replaces them with 0). Register upd_vld=1 and upd_ch=ch_q.
- clr[i] at an edge:
  - Sets size[i]=0, ovf[i]=0, udf[i]=0.
  - Overrides a stage-2 write to i at the same edge. That write is dropped and upd_vld stays 0 for it.
  - An op to channel i accepted at the same edge uses base 0. Bypass from a stage-1 op to i is suppressed.
- Different channels update independently. A stage-2 write to channel a and a stage-1 read of channel b≠a at the same edge do not interact.

## Timing
- Reset (rst high, async): size=0, ovf=0, udf=0, zero=all-ones, upd_vld=0, upd_ch=0, v_q=0. The pipeline is flushed, so an op in flight at reset is lost.
- Latency: op sampled at E0 appears on size and upd_vld after E1, i.e. 2 edges.
- Throughput: one op per cycle on any channel, including back-to-back ops to the same channel, with no bubbles.
- Back-to-back same-channel sequence: ADD 5 at E0, ADD 3 at E1. The final value is old+8 after E2, and the intermediate old+5 is visible after E1.
- zero follows size combinationally, with no extra latency.
- upd_vld is high for exactly one cycle per effective write.

## Test plan
- Reset, then NCH=4 and SW=32: ch1 LOAD 100, ADD 20, ADDHDR hsel=1 on consecutive cycles -> size1 = 100, 120, 168 on successive cycles; upd_vld high 3 cycles with upd_ch=1.
- Saturation: SW=16, ch0 LOAD 0xFFF0, ADD 0x20 -> size0=0xFFFF, ovf[0]=1. Then SUB 0x10 -> 0xFFEF with ovf still 1. Then CLR op -> size0=0, ovf[0]=0.
- Underflow: ch2 LOAD 10, SUB 11 -> size2=0, udf[2]=1, zero[2]=1.
- Clear collision: ch3 ADD 7 issued, then clr[3] at the edge where its write is due, with ch3 ADD 4 accepted at that same edge -> write of 7 is dropped, size3 ends at 4, one upd_vld for ch3.
- Interleave: ADD 1 to ch0, ch1, ch0, ch1 each cycle from 0 -> final ch0=2 and ch1=2. op_ch=5 with NCH=4 -> no change and no upd_vld.
- Async reset asserted mid-stream with 2 ops in flight -> all outputs return to reset values immediately. After release, the first new op completes in 2 edges.
